// File: rtl/mig2stream.sv
// mig2stream: reads a linear frame of packed 16-bit pixels from a MIG read
// port and replays it as a typed pixel stream framed by FRAME_START and
// FRAME_END markers.
// Optional feature macro: MIG2STREAM_ROW_MARKERS_EN adds ROW_START/ROW_END
// markers around every num_cols-pixel row.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 3'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 3'd2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 3'd3
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 3'd4
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 3'd5
`endif

module mig2stream #(
    parameter int ADDR_WIDTH      = 30,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [23:0]             num_pixels,
    input  logic [15:0]             num_cols,
    output logic                    pR_cmd_en,
    output logic [2:0]              pR_cmd_instr,
    output logic [5:0]              pR_cmd_bl,
    output logic [ADDR_WIDTH-1:0]   pR_cmd_byte_addr,
    input  logic                    pR_cmd_full,
    output logic                    pR_rd_en,
    input  logic [31:0]             pR_rd_data,
    input  logic                    pR_rd_empty,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]             datao,
    output logic                    busy,
    output logic                    done
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, SOF, STREAM, EOF, FLUSH} state_t;

    state_t                state;
    state_t                abort_state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [23:0]           words_left;
    logic [23:0]           pix_left;
    logic [24:0]           words_init;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         outstanding_nxt;
    logic                  half;
    logic [4:0]            burst;
    logic                  credit_ok;
    logic                  cmd_go;
    logic                  pix_go;
    logic                  mark;
    logic [15:0]           pix_half;

`ifdef MIG2STREAM_ROW_MARKERS_EN
    logic [15:0] cols_r;
    logic [15:0] row_cnt;
    logic        in_row;
    logic        markers_on;
    logic        mark_rs;
    logic        mark_re;
`else
    logic unused_cols;
    assign unused_cols = ^num_cols;
`endif

    assign pR_cmd_instr = 3'd1;

    // Command credit, marker priority, pixel/pop decisions and counter update.
    always_comb begin
        burst       = (words_left >= 24'd16) ? 5'd16 : words_left[4:0];
        credit_ok   = (32'(outstanding) + 32'(burst)) <= 32'(MAX_OUTSTANDING);
        words_init  = {1'b0, num_pixels} + 25'd1;
`ifdef MIG2STREAM_ROW_MARKERS_EN
        markers_on  = (cols_r != 16'd0);
        mark_rs     = markers_on && !in_row && (pix_left != 24'd0);
        mark_re     = markers_on && in_row && ((row_cnt == cols_r) || (pix_left == 24'd0));
        mark        = mark_rs || mark_re;
`else
        mark        = 1'b0;
`endif
        cmd_go      = (state == STREAM) && enable && (words_left != 24'd0) &&
                      !pR_cmd_full && !pR_cmd_en && credit_ok;
        pix_go      = (state == STREAM) && enable && !mark &&
                      (pix_left != 24'd0) && !pR_rd_empty;
        // The high half pops the word; an odd frame's last low half also pops
        // it so the unused high half is discarded in the same cycle.
        pR_rd_en    = (pix_go && (half || (pix_left == 24'd1))) ||
                      ((state == FLUSH) && !pR_rd_empty);
        pix_half    = half ? pR_rd_data[31:16] : pR_rd_data[15:0];
        outstanding_nxt = outstanding;
        if (cmd_go)
            outstanding_nxt = outstanding_nxt + OW'(burst);
        if (pR_rd_en && (outstanding != '0))
            outstanding_nxt = outstanding_nxt - OW'(1);
        abort_state = (outstanding != '0) ? FLUSH : IDLE;
    end

    // Frame sequencer with registered command and stream outputs.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state            <= IDLE;
            next_addr        <= '0;
            words_left       <= '0;
            pix_left         <= '0;
            outstanding      <= '0;
            half             <= 1'b0;
            pR_cmd_en        <= 1'b0;
            pR_cmd_bl        <= '0;
            pR_cmd_byte_addr <= '0;
            dvo              <= 1'b0;
            dtypeo           <= '0;
            datao            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
`ifdef MIG2STREAM_ROW_MARKERS_EN
            cols_r           <= '0;
            row_cnt          <= '0;
            in_row           <= 1'b0;
`endif
        end else begin
            dvo         <= 1'b0;
            done        <= 1'b0;
            pR_cmd_en   <= 1'b0;
            outstanding <= outstanding_nxt;

            if (cmd_go) begin
                pR_cmd_en        <= 1'b1;
                pR_cmd_bl        <= {1'b0, burst - 5'd1};
                pR_cmd_byte_addr <= next_addr;
                next_addr        <= next_addr + ADDR_WIDTH'(64);
                words_left       <= words_left - {19'd0, burst};
            end

            case (state)
                IDLE: begin
                    if (start && enable) begin
                        next_addr  <= {base_addr[ADDR_WIDTH-1:6], 6'b0};
                        words_left <= words_init[24:1];
                        pix_left   <= num_pixels;
                        half       <= 1'b0;
                        busy       <= 1'b1;
`ifdef MIG2STREAM_ROW_MARKERS_EN
                        cols_r     <= num_cols;
                        row_cnt    <= '0;
                        in_row     <= 1'b0;
`endif
                        state      <= SOF;
                    end
                end
                SOF: begin
                    if (!enable) begin
                        state <= abort_state;
                        busy  <= (abort_state == FLUSH);
                    end else begin
                        dvo    <= 1'b1;
                        dtypeo <= `DTYPE_FRAME_START;
                        datao  <= '0;
                        state  <= (pix_left == 24'd0) ? EOF : STREAM;
                    end
                end
                STREAM: begin
                    if (!enable) begin
                        state <= abort_state;
                        busy  <= (abort_state == FLUSH);
                    end
`ifdef MIG2STREAM_ROW_MARKERS_EN
                    else if (mark_rs) begin
                        dvo    <= 1'b1;
                        dtypeo <= `DTYPE_ROW_START;
                        datao  <= '0;
                        in_row <= 1'b1;
                    end else if (mark_re) begin
                        dvo     <= 1'b1;
                        dtypeo  <= `DTYPE_ROW_END;
                        datao   <= '0;
                        in_row  <= 1'b0;
                        row_cnt <= '0;
                        if (pix_left == 24'd0)
                            state <= EOF;
                    end
`endif
                    else if (pix_go) begin
                        dvo      <= 1'b1;
                        dtypeo   <= `DTYPE_PIXEL;
                        datao    <= pix_half;
                        half     <= ~half;
                        pix_left <= pix_left - 24'd1;
`ifdef MIG2STREAM_ROW_MARKERS_EN
                        row_cnt  <= row_cnt + 16'd1;
                        if ((pix_left == 24'd1) && !markers_on)
                            state <= EOF;
`else
                        if (pix_left == 24'd1)
                            state <= EOF;
`endif
                    end
                end
                EOF: begin
                    if (!enable) begin
                        state <= abort_state;
                        busy  <= (abort_state == FLUSH);
                    end else begin
                        dvo    <= 1'b1;
                        dtypeo <= `DTYPE_FRAME_END;
                        datao  <= '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                FLUSH: begin
                    if (outstanding == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mig2stream.sv
// tb_mig2stream: drives frames into mig2stream against a behavioural MIG
// read-port model; expected stream tokens and commands are queued when each
// frame is started and consumed as the design produces them.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 3'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 3'd2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 3'd3
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 3'd4
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 3'd5
`endif

module tb_mig2stream;

    localparam int AW   = 30;
    localparam int MAXO = 32;
    localparam int SW   = `DTYPE_WIDTH + 16;
`ifdef MIG2STREAM_ROW_MARKERS_EN
    localparam bit ROWS = 1'b1;
`else
    localparam bit ROWS = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    resetb;
    logic                    enable;
    logic                    start;
    logic [AW-1:0]           base_addr;
    logic [23:0]             num_pixels;
    logic [15:0]             num_cols;
    logic                    pR_cmd_en;
    logic [2:0]              pR_cmd_instr;
    logic [5:0]              pR_cmd_bl;
    logic [AW-1:0]           pR_cmd_byte_addr;
    logic                    pR_cmd_full;
    logic                    pR_rd_en;
    logic [31:0]             pR_rd_data;
    logic                    pR_rd_empty;
    logic                    dvo;
    logic [`DTYPE_WIDTH-1:0] dtypeo;
    logic [15:0]             datao;
    logic                    busy;
    logic                    done;

    always #5 clk = ~clk;

    mig2stream #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .resetb(resetb), .enable(enable), .start(start),
        .base_addr(base_addr), .num_pixels(num_pixels), .num_cols(num_cols),
        .pR_cmd_en(pR_cmd_en), .pR_cmd_instr(pR_cmd_instr), .pR_cmd_bl(pR_cmd_bl),
        .pR_cmd_byte_addr(pR_cmd_byte_addr), .pR_cmd_full(pR_cmd_full),
        .pR_rd_en(pR_rd_en), .pR_rd_data(pR_rd_data), .pR_rd_empty(pR_rd_empty),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0]   exp_stream[$];
    logic [AW+5:0]   exp_cmd[$];
    logic [AW-1:0]   mig_q[$];
    bit              rand_mode = 1'b0;
    int              pops = 0;
    int              model_out = 0;
    int              pix_seen = 0;
    int              done_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // MIG read-port model: presents FIFO head before each edge, applies pops and
    // command bursts on the edge.
    initial begin : mig_model
        logic          do_pop;
        logic          do_cmd;
        logic [AW-1:0] cmd_a;
        logic [5:0]    cmd_bl;
        logic [AW-1:0] head_a;
        logic [AW+5:0] ec;
        bit            gate;
        pR_rd_empty = 1'b1;
        pR_rd_data  = 32'hDEAD_BEEF;
        pR_cmd_full = 1'b0;
        forever begin
            @(negedge clk);
            gate = rand_mode ? ($urandom_range(0, 1) == 0) : 1'b1;
            if ((mig_q.size() > 0) && gate) begin
                head_a      = mig_q[0];
                pR_rd_empty = 1'b0;
                pR_rd_data  = {head_a[16:2], 1'b1, head_a[16:2], 1'b0};
            end else begin
                pR_rd_empty = 1'b1;
                pR_rd_data  = 32'hDEAD_BEEF;
            end
            #1;
            do_pop = pR_rd_en && !pR_rd_empty;
            if (pR_rd_en === 1'b1 && pR_rd_empty)
                check_val("rd_en_while_empty", 1, 0);
            do_cmd = (pR_cmd_en === 1'b1) && resetb;
            cmd_a  = pR_cmd_byte_addr;
            cmd_bl = pR_cmd_bl;
            if (do_cmd) begin
                check_val("cmd_instr", pR_cmd_instr, 3'd1);
                if (exp_cmd.size() == 0) begin
                    check_val("cmd_unexpected", 1, 0);
                end else begin
                    ec = exp_cmd.pop_front();
                    check_val("cmd_addr", cmd_a, ec[AW+5:6]);
                    check_val("cmd_bl", cmd_bl, ec[5:0]);
                end
            end
            @(posedge clk);
            if (do_pop === 1'b1) begin
                void'(mig_q.pop_front());
                pops++;
                model_out--;
            end
            if (do_cmd) begin
                for (int i = 0; i <= int'(cmd_bl); i++)
                    mig_q.push_back(cmd_a + AW'(4 * i));
                model_out += int'(cmd_bl) + 1;
                check_val("outstanding_le_max", (model_out <= MAXO), 1);
            end
        end
    end

    // Output stream checker against the expected-token queue.
    initial begin : stream_checker
        logic [SW-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (resetb) begin
                if (dvo === 1'b1) begin
                    if (exp_stream.size() == 0) begin
                        check_val("dvo_unexpected", {dtypeo, datao}, 0);
                    end else begin
                        e = exp_stream.pop_front();
                        check_val("dtype", dtypeo, e[SW-1:16]);
                        check_val("data", datao, e[15:0]);
                        if (dtypeo == `DTYPE_PIXEL)
                            pix_seen++;
                    end
                end
                if (dvo === 1'b1 || done === 1'b1)
                    check_val("done_with_frame_end", done, (dvo && dtypeo == `DTYPE_FRAME_END));
                if (done === 1'b1)
                    done_cnt++;
            end
        end
    end

    task automatic push_frame(input logic [AW-1:0] base, input int np, input int nc, input int keep_pix);
        logic [AW-1:0] ab;
        logic [AW-1:0] a;
        int            words;
        int            b;
        int            row;
        ab  = {base[AW-1:6], 6'b0};
        row = 0;
        exp_stream.push_back({`DTYPE_FRAME_START, 16'h0});
        for (int p = 0; p < keep_pix; p++) begin
            if (ROWS && nc != 0 && row == 0)
                exp_stream.push_back({`DTYPE_ROW_START, 16'h0});
            exp_stream.push_back({`DTYPE_PIXEL, 16'((ab >> 1) + AW'(p))});
            row++;
            if (ROWS && nc != 0 && row == nc) begin
                exp_stream.push_back({`DTYPE_ROW_END, 16'h0});
                row = 0;
            end
        end
        if (keep_pix == np) begin
            if (ROWS && nc != 0 && row != 0)
                exp_stream.push_back({`DTYPE_ROW_END, 16'h0});
            exp_stream.push_back({`DTYPE_FRAME_END, 16'h0});
        end
        words = (np + 1) / 2;
        a     = ab;
        while (words > 0) begin
            b = (words > 16) ? 16 : words;
            exp_cmd.push_back({a, 6'(b - 1)});
            a     = a + AW'(64);
            words = words - b;
        end
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input int np, input int nc);
        @(negedge clk);
        base_addr  = base;
        num_pixels = 24'(np);
        num_cols   = 16'(nc);
        enable     = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val({tag, "_finished"}, ok, 1);
    endtask

    task automatic run_frame(input string tag, input logic [AW-1:0] base, input int np,
                             input int nc, input bit rnd, input bit restart);
        rand_mode = rnd;
        pops      = 0;
        done_cnt  = 0;
        pix_seen  = 0;
        push_frame(base, np, nc, np);
        start_frame(base, np, nc);
        check_val({tag, "_busy"}, busy, 1);
        if (restart) begin
            repeat (5) @(negedge clk);
            base_addr  = '0;
            num_pixels = 24'd7;
            start      = 1'b1;
            @(negedge clk);
            start      = 1'b0;
        end
        wait_idle(tag, 4000);
        repeat (2) @(negedge clk);
        #2;
        check_val({tag, "_stream_left"}, exp_stream.size(), 0);
        check_val({tag, "_cmds_left"}, exp_cmd.size(), 0);
        check_val({tag, "_mig_left"}, mig_q.size(), 0);
        check_val({tag, "_pops"}, pops, (np + 1) / 2);
        check_val({tag, "_pixels"}, pix_seen, np);
        check_val({tag, "_done_cnt"}, done_cnt, 1);
        check_val({tag, "_model_out"}, model_out, 0);
    endtask

    initial begin : stimulus
        int p0;
        bit ok;
        resetb     = 1'b0;
        enable     = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_pixels = '0;
        num_cols   = '0;
        repeat (3) @(negedge clk);
        check_val("rst_dvo", dvo, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cmd_en", pR_cmd_en, 0);
        check_val("rst_cmd_bl", pR_cmd_bl, 0);
        check_val("rst_cmd_addr", pR_cmd_byte_addr, 0);
        check_val("rst_dtype", dtypeo, 0);
        check_val("rst_data", datao, 0);
        check_val("rst_rd_en", pR_rd_en, 0);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        // start ignored while enable is low
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("start_no_enable_busy", busy, 0);

        run_frame("f64", 30'h1000, 64, 0, 1'b0, 1'b1);
        run_frame("f35", 30'h2000, 35, 0, 1'b0, 1'b0);
        run_frame("rand100", 30'h3055, 100, 0, 1'b1, 1'b0);
        run_frame("wrap", 30'h3FFF_FFC0, 64, 0, 1'b0, 1'b0);
        run_frame("zero", 30'h5000, 0, 0, 1'b0, 1'b0);

        // abort: enable dropped after ten pixels, remaining words flushed
        rand_mode = 1'b0;
        pops      = 0;
        done_cnt  = 0;
        pix_seen  = 0;
        push_frame(30'h8000, 50, 0, 10);
        start_frame(30'h8000, 50, 0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (pix_seen >= 10) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("abort_reach_10px", ok, 1);
        enable = 1'b0;
        p0 = pops;
        check_val("abort_pops_before", p0, 5);
        wait_idle("abort", 500);
        repeat (3) @(negedge clk);
        #2;
        check_val("abort_flush_pops", pops - p0, 20);
        check_val("abort_busy", busy, 0);
        check_val("abort_done_cnt", done_cnt, 0);
        check_val("abort_stream_left", exp_stream.size(), 0);
        check_val("abort_cmds_left", exp_cmd.size(), 0);
        check_val("abort_mig_left", mig_q.size(), 0);
        check_val("abort_model_out", model_out, 0);

        run_frame("after_abort", 30'h9000, 17, 0, 1'b1, 1'b0);

`ifdef MIG2STREAM_ROW_MARKERS_EN
        run_frame("rows4x10", 30'hA000, 10, 4, 1'b0, 1'b0);
        run_frame("rows5x13", 30'hB000, 13, 5, 1'b1, 1'b0);
        run_frame("rows_off", 30'hC000, 6, 0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
